// File: rtl/ahb_read_capture_if.sv
// ahb_read_capture_if: bus bundle between the AHB master FSM / register file
// and the read-data capture stage. The slave modport is the capture stage's view.
interface ahb_read_capture_if #(
  parameter int DATA_W     = 32,
  parameter int RADDR_W    = 5,
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [5:0]         state;
  logic [DATA_W-1:0]  HRDATA;
  logic               HREADY;
  logic               HRESP;
  logic [RADDR_W-1:0] ADDR;
  logic               REG_READY;
  logic               CLR_FLAGS;
  logic [DATA_W-1:0]  RESPONSE;
  logic [RADDR_W-1:0] RESPONSE_ADDR;
  logic               REG_ENABLE;
  logic               REG_WRITE;
  logic [LVL_W-1:0]   FIFO_LEVEL;
  logic               OVERFLOW;
  logic               ERR;

  modport master (
    output state, HRDATA, HREADY, HRESP, ADDR, REG_READY, CLR_FLAGS,
    input  RESPONSE, RESPONSE_ADDR, REG_ENABLE, REG_WRITE, FIFO_LEVEL, OVERFLOW, ERR
  );

  modport slave (
    input  state, HRDATA, HREADY, HRESP, ADDR, REG_READY, CLR_FLAGS,
    output RESPONSE, RESPONSE_ADDR, REG_ENABLE, REG_WRITE, FIFO_LEVEL, OVERFLOW, ERR
  );
endinterface

// File: rtl/ahb_read_capture.sv
// ahb_read_capture: captures HRDATA beats of single / incrementing-burst reads,
// tags them with an auto-incrementing register address, buffers them in a small
// FIFO and drains them into the register-file write port under REG_READY.
// Optional feature macro: AHB_RD_ERR_EN (ERROR responses abort the burst and set ERR).
module ahb_read_capture #(
  parameter int DATA_W     = 32,
  parameter int RADDR_W    = 5,
  parameter int ADDR_STEP  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic              HCLK,
  input logic              HRESETn,
  ahb_read_capture_if.slave bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = RADDR_W + DATA_W;

  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_SBURSTW = 6'b000010,
    ST_SBURSTR = 6'b000100,
    ST_INCRBW  = 6'b001000,
    ST_INCRBR  = 6'b010000,
    ST_BUSY    = 6'b100000
  } mst_state_e;

  typedef enum logic [1:0] {C_IDLE, C_SINGLE, C_BURST} cap_state_e;

  cap_state_e         cap_q;
  logic [5:0]         prev_state_q;
  logic [RADDR_W-1:0] ptr_q;
  logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]  resp_q;
  logic [RADDR_W-1:0] resp_addr_q;
  logic               en_q, ovf_q, err_q;

  logic               capture, beat_err, push_req, push, pop, full, drop;
  logic [ENT_W-1:0]   head;

  // Capture qualification and FIFO push/pop decisions
  always_comb begin
    capture  = (cap_q != C_IDLE) && bus.HREADY && (prev_state_q != ST_BUSY);
`ifdef AHB_RD_ERR_EN
    beat_err = capture && bus.HRESP;
`else
    beat_err = 1'b0;
`endif
    push_req = capture && !beat_err;
    full     = (count_q == LVL_W'(FIFO_DEPTH));
    pop      = (count_q != '0) && bus.REG_READY;
    // a pop on the same edge frees the slot, so a full FIFO still accepts
    push     = push_req && (!full || pop);
    drop     = push_req && full && !pop;
    count_d  = count_q + LVL_W'(push) - LVL_W'(pop);
    head     = mem_q[rd_ptr_q];
  end

`ifndef AHB_RD_ERR_EN
  logic unused_hresp;
  assign unused_hresp = bus.HRESP;
`endif

  // Capture FSM with beat-address pointer and previous master state
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cap_q        <= C_IDLE;
      prev_state_q <= ST_IDLE;
      ptr_q        <= '0;
    end else begin
      prev_state_q <= bus.state;
      case (cap_q)
        C_IDLE: begin
          if (bus.state == ST_SBURSTR) begin
            cap_q <= C_SINGLE;
            ptr_q <= bus.ADDR;
          end else if (bus.state == ST_INCRBR) begin
            cap_q <= C_BURST;
            ptr_q <= bus.ADDR;
          end
        end
        C_SINGLE: begin
          if (capture) cap_q <= C_IDLE;
        end
        C_BURST: begin
          // pointer advances on every captured beat, even a dropped one
          if (capture) ptr_q <= ptr_q + RADDR_W'(ADDR_STEP);
          if (beat_err) begin
            cap_q <= C_IDLE;
          end else if (bus.state == ST_SBURSTR) begin
            cap_q <= C_SINGLE;
            ptr_q <= bus.ADDR;
          end else if (bus.state != ST_INCRBR && bus.state != ST_BUSY) begin
            cap_q <= C_IDLE;
          end
        end
        default: cap_q <= C_IDLE;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while the level is zero
  always_ff @(posedge HCLK) begin
    if (push) mem_q[wr_ptr_q] <= {ptr_q, bus.HRDATA};
  end

  // FIFO pointers, registered write port and sticky flags
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      resp_q      <= '0;
      resp_addr_q <= '0;
      en_q        <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + PTR_W'(1);
        resp_q      <= head[DATA_W-1:0];
        resp_addr_q <= head[DATA_W +: RADDR_W];
      end
      count_q <= count_d;
      en_q    <= pop;
      ovf_q   <= drop || (ovf_q && !bus.CLR_FLAGS);
      err_q   <= beat_err || (err_q && !bus.CLR_FLAGS);
    end
  end

  assign bus.RESPONSE      = resp_q;
  assign bus.RESPONSE_ADDR = resp_addr_q;
  assign bus.REG_ENABLE    = en_q;
  assign bus.REG_WRITE     = en_q;
  assign bus.FIFO_LEVEL    = count_q;
  assign bus.OVERFLOW      = ovf_q;
  assign bus.ERR           = err_q;
endmodule

// File: tb/tb_ahb_read_capture.sv
// tb_ahb_read_capture: directed bench for ahb_read_capture with hand-computed
// expected register-file writes.
module tb_ahb_read_capture;
  localparam logic [5:0] S_IDLE = 6'b000001, S_SBW = 6'b000010, S_SBR = 6'b000100,
                         S_IBW = 6'b001000, S_IBR = 6'b010000, S_BUSY = 6'b100000;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  int checks = 0;
  int fails = 0;
  int strobe_bad = 0;
  logic [36:0] wq [$];
  logic [36:0] exp_q [$];

  always #5 HCLK = ~HCLK;

  ahb_read_capture_if #(.DATA_W(32), .RADDR_W(5), .FIFO_DEPTH(4)) bus ();

  ahb_read_capture #(.DATA_W(32), .RADDR_W(5), .ADDR_STEP(1), .FIFO_DEPTH(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus)
  );

  // record every write strobe seen on the register-file port
  always @(negedge HCLK) begin
    if (bus.REG_WRITE !== bus.REG_ENABLE) strobe_bad++;
    if (bus.REG_ENABLE === 1'b1) wq.push_back({bus.RESPONSE_ADDR, bus.RESPONSE});
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ent(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic check_writes(input string tag);
    logic [36:0] got;
    chk({tag, " count"}, 64'(wq.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < wq.size()) ? wq[i] : 'x;
      checks++;
      assert (got === exp_q[i]) else begin
        fails++;
        $error("FAIL %s write %0d: observed addr %0d data %h expected addr %0d data %h",
               tag, i, got[36:32], got[31:0], exp_q[i][36:32], exp_q[i][31:0]);
      end
    end
    wq.delete();
    exp_q.delete();
  endtask

  task automatic arm(input logic [5:0] st, input logic [4:0] a);
    bus.state = st; bus.ADDR = a; bus.HREADY = 1'b0;
    tick();
  endtask

  task automatic beat(input logic [5:0] st, input logic [31:0] d);
    bus.state = st; bus.HRDATA = d; bus.HREADY = 1'b1;
    tick();
  endtask

  task automatic quiet(input int n);
    bus.state = S_IDLE; bus.HREADY = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    bus.state = S_IDLE; bus.HRDATA = '0; bus.HREADY = 1'b0; bus.HRESP = 1'b0;
    bus.ADDR = '0; bus.REG_READY = 1'b0; bus.CLR_FLAGS = 1'b0;

    // reset values
    repeat (2) tick();
    chk("rst RESPONSE", 64'(bus.RESPONSE), 64'h0);
    chk("rst RESPONSE_ADDR", 64'(bus.RESPONSE_ADDR), 64'h0);
    chk("rst REG_ENABLE", 64'(bus.REG_ENABLE), 64'h0);
    chk("rst FIFO_LEVEL", 64'(bus.FIFO_LEVEL), 64'h0);
    chk("rst OVERFLOW", 64'(bus.OVERFLOW), 64'h0);
    chk("rst ERR", 64'(bus.ERR), 64'h0);
    HRESETn = 1'b1;
    tick();

    // single read: one-cycle strobe, data/addr held afterwards
    bus.REG_READY = 1'b1;
    arm(S_SBR, 5'd3);
    beat(S_IDLE, 32'hDEADBEEF);
    chk("single level after capture", 64'(bus.FIFO_LEVEL), 64'h1);
    chk("single no early strobe", 64'(bus.REG_ENABLE), 64'h0);
    quiet(1);
    chk("single strobe", 64'(bus.REG_ENABLE), 64'h1);
    chk("single REG_WRITE", 64'(bus.REG_WRITE), 64'h1);
    chk("single RESPONSE", 64'(bus.RESPONSE), 64'hDEADBEEF);
    chk("single RESPONSE_ADDR", 64'(bus.RESPONSE_ADDR), 64'h3);
    chk("single level drained", 64'(bus.FIFO_LEVEL), 64'h0);
    quiet(1);
    chk("single strobe drops", 64'(bus.REG_ENABLE), 64'h0);
    chk("single RESPONSE held", 64'(bus.RESPONSE), 64'hDEADBEEF);
    wq.delete();

    // writes and IDLE are never captured
    beat(S_SBW, 32'h11111111);
    beat(S_IBW, 32'h22222222);
    beat(S_IBW, 32'h33333333);
    beat(S_IDLE, 32'h44444444);
    quiet(3);
    check_writes("no capture on writes");

    // incrementing burst wrapping at 5 bits
    arm(S_IBR, 5'd30);
    beat(S_IBR, 32'hA0000000);
    beat(S_IBR, 32'hA0000001);
    beat(S_IBR, 32'hA0000002);
    beat(S_IDLE, 32'hA0000003);
    quiet(3);
    ent(5'd30, 32'hA0000000); ent(5'd31, 32'hA0000001);
    ent(5'd0, 32'hA0000002); ent(5'd1, 32'hA0000003);
    check_writes("burst wrap");

    // BUSY slot: the following beat is skipped, addresses stay contiguous
    arm(S_IBR, 5'd10);
    beat(S_BUSY, 32'hB0000000);
    beat(S_IBR, 32'hBADBAD00);
    beat(S_IDLE, 32'hB0000002);
    quiet(3);
    ent(5'd10, 32'hB0000000); ent(5'd11, 32'hB0000002);
    check_writes("busy insertion");

    // backpressure: 6 beats into a 4-deep FIFO
    bus.REG_READY = 1'b0;
    arm(S_IBR, 5'd8);
    for (int i = 0; i < 6; i++) beat((i == 5) ? S_IDLE : S_IBR, 32'hC0000000 + 32'(i));
    quiet(1);
    chk("ovf level full", 64'(bus.FIFO_LEVEL), 64'h4);
    chk("ovf flag", 64'(bus.OVERFLOW), 64'h1);
    chk("ovf no strobe", 64'(bus.REG_ENABLE), 64'h0);
    bus.REG_READY = 1'b1;
    quiet(6);
    for (int i = 0; i < 4; i++) ent(5'(8 + i), 32'hC0000000 + 32'(i));
    check_writes("overflow drain");
    bus.CLR_FLAGS = 1'b1;
    tick();
    bus.CLR_FLAGS = 1'b0;
    chk("ovf cleared", 64'(bus.OVERFLOW), 64'h0);

    // drop advances the pointer; push+pop when full accepted; event beats clear
    bus.REG_READY = 1'b0;
    arm(S_IBR, 5'd20);
    for (int i = 0; i < 4; i++) beat(S_IBR, 32'hD0000000 + 32'(i));
    bus.CLR_FLAGS = 1'b1;
    beat(S_IBR, 32'hD0000004);
    bus.CLR_FLAGS = 1'b0;
    chk("ovf wins over clear", 64'(bus.OVERFLOW), 64'h1);
    chk("full level", 64'(bus.FIFO_LEVEL), 64'h4);
    bus.REG_READY = 1'b1;
    beat(S_IDLE, 32'hD0000005);
    chk("push+pop full level", 64'(bus.FIFO_LEVEL), 64'h4);
    chk("push+pop strobe addr", 64'(bus.RESPONSE_ADDR), 64'd20);
    quiet(6);
    for (int i = 0; i < 4; i++) ent(5'(20 + i), 32'hD0000000 + 32'(i));
    ent(5'd25, 32'hD0000005);
    check_writes("drop then push+pop");

    // ERROR response on beat 2 of 4
    arm(S_IBR, 5'd4);
    beat(S_IBR, 32'hE0000000);
    beat(S_IBR, 32'hE0000001);
    bus.HRESP = 1'b1;
    beat(S_IBR, 32'hE0000002);
    bus.HRESP = 1'b0;
    beat(S_IDLE, 32'hE0000003);
    quiet(3);
    ent(5'd4, 32'hE0000000); ent(5'd5, 32'hE0000001);
`ifdef AHB_RD_ERR_EN
    check_writes("error abort");
    chk("err set", 64'(bus.ERR), 64'h1);
    bus.CLR_FLAGS = 1'b1;
    tick();
    bus.CLR_FLAGS = 1'b0;
    chk("err cleared", 64'(bus.ERR), 64'h0);
`else
    ent(5'd6, 32'hE0000002); ent(5'd7, 32'hE0000003);
    check_writes("hresp ignored");
    chk("err tied low", 64'(bus.ERR), 64'h0);
`endif

    // reset mid-burst with 3 buffered beats
    bus.REG_READY = 1'b0;
    arm(S_IBR, 5'd2);
    beat(S_IBR, 32'hF0000000);
    beat(S_IBR, 32'hF0000001);
    beat(S_IDLE, 32'hF0000002);
    quiet(1);
    chk("pre-reset level", 64'(bus.FIFO_LEVEL), 64'h3);
    #1 HRESETn = 1'b0;
    #1;
    chk("mid rst RESPONSE", 64'(bus.RESPONSE), 64'h0);
    chk("mid rst RESPONSE_ADDR", 64'(bus.RESPONSE_ADDR), 64'h0);
    chk("mid rst REG_ENABLE", 64'(bus.REG_ENABLE), 64'h0);
    chk("mid rst FIFO_LEVEL", 64'(bus.FIFO_LEVEL), 64'h0);
    chk("mid rst OVERFLOW", 64'(bus.OVERFLOW), 64'h0);
    chk("mid rst ERR", 64'(bus.ERR), 64'h0);
    tick();
    HRESETn = 1'b1;
    bus.REG_READY = 1'b1;
    quiet(4);
    check_writes("no strobes after reset");
    chk("post rst level", 64'(bus.FIFO_LEVEL), 64'h0);

    // a fresh read works after reset
    arm(S_SBR, 5'd7);
    beat(S_IDLE, 32'h12345678);
    quiet(3);
    ent(5'd7, 32'h12345678);
    check_writes("read after reset");

    chk("REG_WRITE tracks REG_ENABLE", 64'(strobe_bad), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/ahb_read_capture.md
# ahb_read_capture

Parametrised read-data capture stage between the AHB master interface and the CPU register file. It follows the master FSM's one-hot `state`. It captures `HRDATA` beats from single and incrementing-burst reads, tags each beat with an auto-incrementing destination register address, and buffers the beats in a small FIFO. The FIFO drains into the register-file write port under `REG_READY` backpressure, and sticky overflow and error flags are exposed.

## Interface
- `DATA_W`, 32: width of HRDATA/RESPONSE.
- `RADDR_W`, 5: register-file address width.
- `ADDR_STEP`, 1: per-beat destination address increment, modulo 2^RADDR_W.
- `FIFO_DEPTH`, 4: buffer entries; power of two, ≥2.
- `HCLK` in 1: sole clock, rising edge.
- `HRESETn` in 1: asynchronous, active-low reset.
- `state` in 6: master FSM one-hot; IDLE=000001, SBURSTW=000010, SBURSTR=000100, INCRBW=001000, INCRBR=010000, BUSY=100000.
- `HRDATA` in DATA_W: AHB read data.
- `HREADY` in 1: transfer-complete strobe.
- `HRESP` in 1: 1 = ERROR response.
- `ADDR` in RADDR_W: destination register for the first beat.
- `REG_READY` in 1: register file accepts a write this cycle.
- `CLR_FLAGS` in 1: synchronous clear of the sticky flags.
- `RESPONSE` out DATA_W: write data.
- `RESPONSE_ADDR` out RADDR_W: write address.
- `REG_ENABLE`, `REG_WRITE` out 1 each: write strobes, always equal.
- `FIFO_LEVEL` out $clog2(FIFO_DEPTH)+1: occupied entries.
- `OVERFLOW` out 1: sticky; a beat was dropped because the FIFO was full.
- `ERR` out 1: sticky ERROR response seen. Tied 0 unless AHB_RD_ERR_EN is defined.

## Operation
- Capture FSM states: C_IDLE, C_SINGLE, C_BURST.
- Register `prev_state` holds `state` from the previous cycle.
- C_IDLE → C_SINGLE when `state`==SBURSTR. The beat pointer loads `ADDR`.
- C_IDLE → C_BURST when `state`==INCRBR. The beat pointer loads `ADDR`.
- C_SINGLE → C_IDLE after one captured beat.
- C_BURST stays while `state` is INCRBR or BUSY. Any other state returns it to C_IDLE.
- In C_BURST, `state`==SBURSTR goes directly to C_SINGLE and reloads `ADDR`.
- Re-entering INCRBR while in C_BURST does not reload the pointer.
- Capture condition: FSM in C_SINGLE or C_BURST, `HREADY`=1, and `prev_state`≠BUSY. BUSY slots carry no data.
- On capture, push {pointer, HRDATA}. In C_BURST, the pointer then advances by ADDR_STEP and wraps naturally at RADDR_W bits.
- FIFO full at capture: the beat is dropped and `OVERFLOW` is set. The burst pointer still advances, so later beats keep their correct addresses.
- A push and a pop on the same edge are always legal, including when full. The pop frees the slot, so the push is accepted.
- Drain: when the FIFO is non-empty and `REG_READY`=1, pop the head into registered `RESPONSE`/`RESPONSE_ADDR` and assert the strobes for exactly one cycle.
- When there is no pop, the strobes are 0. `RESPONSE`/`RESPONSE_ADDR` hold their last value.
- Writes (SBURSTW, INCRBW) and IDLE are never captured.
- `CLR_FLAGS` clears `OVERFLOW`/`ERR`. An event in the same cycle wins, and the flag stays set.

## Timing
- Reset values: every output is 0, the FIFO is empty, the FSM is C_IDLE, and `prev_state` = IDLE.
- Reset mid-burst discards all buffered beats immediately.
- Arming is registered, so the earliest capture is the edge after the one that samples SBURSTR/INCRBR.
- Latency: a beat captured at edge N is presented with `REG_ENABLE`=1 after edge N+1, provided `REG_READY`=1 at N+1.
- Throughput is one beat per cycle, sustained, with `REG_READY` held at 1.
- `FIFO_LEVEL` updates on the same edge as the push or pop.

## Configuration
- Macro: `AHB_RD_ERR_EN`.
- Defined:
  - A capture-condition beat with `HRESP`=1 is not pushed.
  - `ERR` is set and the FSM returns to C_IDLE, aborting the burst.
  - Entries already in the FIFO still drain.
- Undefined: `HRESP` is ignored, every beat is pushed, and `ERR` is tied 0.

## Test plan
- Single read:
  - Stimulus: `ADDR`=5'd3, SBURSTR, HRDATA=32'hDEADBEEF with HREADY.
  - Response: one strobe cycle, RESPONSE_ADDR=3, RESPONSE=DEADBEEF, FIFO_LEVEL back to 0.
- Burst with wrap:
  - Stimulus: `ADDR`=30, ADDR_STEP=1, 4 beats A0..A3.
  - Response: writes to 30, 31, 0, 1 in order.
- BUSY insertion:
  - Stimulus: INCRBR, BUSY, INCRBR with HREADY held at 1.
  - Response: the beat following the BUSY slot is skipped, and the addresses stay contiguous.
- Backpressure and overflow:
  - Stimulus: `REG_READY`=0, 6-beat burst, FIFO_DEPTH=4.
  - Response: FIFO_LEVEL=4 and OVERFLOW=1. After REG_READY is raised, only beats 0–3 are written, at ADDR+0..3.
- Error (AHB_RD_ERR_EN defined):
  - Stimulus: HRESP=1 on beat 2 of 4.
  - Response: beats 0–1 are written, ERR=1, no further captures. Then CLR_FLAGS → ERR=0.
- Reset mid-burst:
  - Stimulus: HRESETn low with 3 entries buffered.
  - Response: all outputs 0 and FIFO_LEVEL=0. No strobes after release until a new read.
